// File: rtl/icetap_recorder.sv
// icetap capture engine: samples the probed signals, evaluates the store/trigger masks,
// records into a circular RAM and serves sequential readback, all on src_clk.
module icetap_recorder #(
  parameter int NR_SIGNALS      = 16,
  parameter int RECORD_DEPTH    = 256,
  parameter int POST_SAMPLES    = 128,
  parameter bit COMPLEX_STORE   = 1'b1,
  parameter bit COMPLEX_TRIGGER = 1'b1,
  localparam int RAM_ADDR_BITS  = $clog2(RECORD_DEPTH)
) (
  input  logic                      src_clk,
  input  logic                      src_reset,
  input  logic [NR_SIGNALS-1:0]     signals_in,
  input  logic                      start,
  input  logic                      store_always,
  input  logic                      trigger_always,
  input  logic [3*NR_SIGNALS-1:0]   store_mask_vec,
  input  logic [3*NR_SIGNALS-1:0]   trigger_mask_vec,
  output logic [1:0]                state,
  output logic [RAM_ADDR_BITS-1:0]  start_addr,
  output logic [RAM_ADDR_BITS-1:0]  trigger_addr,
  output logic [RAM_ADDR_BITS-1:0]  stop_addr,
  input  logic                      read_req_first,
  input  logic                      read_req_next,
  output logic [NR_SIGNALS-1:0]     read_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PRE  = 2'd1;
  localparam logic [1:0] POST = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int                 CNT_W       = RAM_ADDR_BITS + 1;
  localparam logic [CNT_W-1:0]   FULL        = CNT_W'(RECORD_DEPTH);
  localparam logic [CNT_W-1:0]   POST_TARGET = CNT_W'(POST_SAMPLES);

  // Each signal contributes a care bit and a term; codes 0 and 7 leave care low.
  function automatic logic mask_match(input logic [3*NR_SIGNALS-1:0] mask,
                                      input logic [NR_SIGNALS-1:0]   cur,
                                      input logic [NR_SIGNALS-1:0]   prev);
    logic [NR_SIGNALS-1:0] care;
    logic [NR_SIGNALS-1:0] term;
    care = '0;
    term = '0;
    for (int i = 0; i < NR_SIGNALS; i++) begin
      case (mask[3*i +: 3])
        3'd1: begin care[i] = 1'b1; term[i] = ~cur[i];            end
        3'd2: begin care[i] = 1'b1; term[i] = cur[i];             end
        3'd3: begin care[i] = 1'b1; term[i] = ~prev[i] & cur[i];  end
        3'd4: begin care[i] = 1'b1; term[i] = prev[i] & ~cur[i];  end
        3'd5: begin care[i] = 1'b1; term[i] = prev[i] ^ cur[i];   end
        3'd6: begin care[i] = 1'b1; term[i] = ~(prev[i] ^ cur[i]); end
        default: ;
      endcase
    end
    return (|care) & (&(term | ~care));
  endfunction

  logic [NR_SIGNALS-1:0]     s;
  logic [NR_SIGNALS-1:0]     p;
  logic [RAM_ADDR_BITS-1:0]  wr_addr;
  logic [CNT_W-1:0]          fill;
  logic [CNT_W-1:0]          post_cnt;
  logic [RAM_ADDR_BITS-1:0]  rd_addr;
  logic [RAM_ADDR_BITS-1:0]  rd_next;
  logic                      rd_en;
  logic                      rd_pend;
  logic [NR_SIGNALS-1:0]     ram [RECORD_DEPTH];
  logic [NR_SIGNALS-1:0]     ram_q;
  logic                      store;
  logic                      trig;
  logic                      do_write;

  assign store = store_always |
                 (COMPLEX_STORE ? mask_match(store_mask_vec, s, p) : 1'b0);
  assign trig  = trigger_always |
                 (COMPLEX_TRIGGER ? mask_match(trigger_mask_vec, s, p) : 1'b0);

  // A start pulse restarts the recording and suppresses the write of that cycle.
  always_comb begin
    do_write = 1'b0;
    if (!src_reset && !start) begin
      case (state)
        PRE:     do_write = trig | store;
        POST:    do_write = store;
        default: do_write = 1'b0;
      endcase
    end
  end

  always_ff @(posedge src_clk) begin
    if (src_reset) begin
      s <= '0;
      p <= '0;
    end else begin
      s <= signals_in;
      p <= s;
    end
  end

  always_ff @(posedge src_clk) begin
    if (src_reset) begin
      state        <= IDLE;
      wr_addr      <= '0;
      fill         <= '0;
      post_cnt     <= '0;
      start_addr   <= '0;
      trigger_addr <= '0;
      stop_addr    <= '0;
    end else if (start) begin
      state        <= PRE;
      wr_addr      <= '0;
      fill         <= '0;
      post_cnt     <= '0;
      start_addr   <= '0;
      trigger_addr <= '0;
      stop_addr    <= '0;
    end else begin
      if (do_write) begin
        wr_addr <= wr_addr + 1'b1;
        // Once the ring is full every write evicts the oldest sample.
        if (fill == FULL) start_addr <= wr_addr + 1'b1;
        else              fill       <= fill + 1'b1;
      end
      case (state)
        PRE: begin
          if (trig) begin
            trigger_addr <= wr_addr;
            post_cnt     <= '0;
            if (POST_SAMPLES == 0) begin
              stop_addr <= wr_addr;
              state     <= DONE;
            end else begin
              state <= POST;
            end
          end
        end
        POST: begin
          if (store) begin
            post_cnt <= post_cnt + 1'b1;
            if (post_cnt + 1'b1 == POST_TARGET) begin
              stop_addr <= wr_addr;
              state     <= DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read requests are only honoured while not recording.
  always_comb begin
    rd_en   = 1'b0;
    rd_next = rd_addr;
    if (!src_reset && (state == IDLE || state == DONE)) begin
      if (read_req_first) begin
        rd_en   = 1'b1;
        rd_next = start_addr;
      end else if (read_req_next) begin
        rd_en   = 1'b1;
        rd_next = rd_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge src_clk) begin
    if (do_write) ram[wr_addr] <= s;
    if (rd_en)    ram_q        <= ram[rd_next];
  end

  always_ff @(posedge src_clk) begin
    if (src_reset) begin
      rd_addr   <= '0;
      rd_pend   <= 1'b0;
      read_data <= '0;
    end else begin
      rd_pend <= rd_en;
      if (rd_en)   rd_addr   <= rd_next;
      if (rd_pend) read_data <= ram_q;
    end
  end

endmodule
